// File: rtl/ysyx_23060191_mem_arbiter.sv
// ============================================================================
// Module  : ysyx_23060191_mem_arbiter
// Brief   : Shares one memory port between IFU fetch and LSU load/store,
//           one transaction in flight. YSYX_23060191_ARB_RR_EN selects
//           round-robin arbitration instead of fixed LSU priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060191_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              ifu_resp_q, ifu_resp_d;
    logic              lsu_resp_q, lsu_resp_d;
    logic              arb_err_q, arb_err_d;
    logic              grant_lsu;
    logic              accept;

`ifdef YSYX_23060191_ARB_RR_EN
    logic rr_last_lsu_q, rr_last_lsu_d;

    // On contention the grant goes to whoever did not win last time.
    assign grant_lsu     = lsu_req_valid && (!ifu_req_valid || !rr_last_lsu_q);
    assign rr_last_lsu_d = accept ? grant_lsu : rr_last_lsu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_lsu_q <= 1'b0;
        end else begin
            rr_last_lsu_q <= rr_last_lsu_d;
        end
    end
`else
    assign grant_lsu = lsu_req_valid;
`endif

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign accept        = (state_q == S_IDLE) && !rst && (ifu_req_valid || lsu_req_valid);
    assign lsu_req_ready = accept && grant_lsu;
    assign ifu_req_ready = accept && !grant_lsu;

    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign arb_err        = arb_err_q;

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        arb_err_d   = arb_err_q || (mem_resp_valid && (state_q != S_WAIT));
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_lsu_d = grant_lsu;
                    state_d     = S_REQ;
                    if (grant_lsu) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                    if (owner_lsu_q) begin
                        lsu_rdata_d = mem_rdata;
                        lsu_resp_d  = 1'b1;
                    end else begin
                        ifu_rdata_d = mem_rdata;
                        ifu_resp_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            arb_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            arb_err_q   <= arb_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// ============================================================================
// Module  : tb_ysyx_23060191_mem_arbiter
// Brief   : Directed self-checking bench for the IFU/LSU memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060191_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        arb_err;

    int total;
    int bad;

    ysyx_23060191_mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MASK_W(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .arb_err       (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        tick; tick;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, arb_err, mem_wen} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, arb_err, mem_wen});
        end
        total++;
        if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wdata=%h wmask=%h ifu_rdata=%h lsu_rdata=%h want all 0",
                     mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
        end
        tick;
        rst = 1'b0;
    endtask

    // Requesters hold valid for a fixed number of grants; the bench memory
    // accepts immediately and responds the following cycle.
    task automatic test_simultaneous;
        int lg, ig, ng, nr, lsu_n, ifu_n;
        logic pend, both;
        logic [3:0] gseq, rseq, exp_seq;
        lg = 0; ig = 0; ng = 0; nr = 0; pend = 1'b0; both = 1'b0;
        gseq = '0; rseq = '0;
`ifdef YSYX_23060191_ARB_RR_EN
        lsu_n = 2; ifu_n = 2; exp_seq = 4'b0101;
`else
        lsu_n = 3; ifu_n = 1; exp_seq = 4'b0111;
`endif
        for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            tick;
            mem_resp_valid = pend;
            mem_rdata      = 32'hC0DE_0000 + cyc;
            pend           = 1'b0;
            mem_req_ready  = mem_req_valid;
            if (mem_req_valid) pend = 1'b1;
            lsu_req_valid = (lg < lsu_n);
            lsu_addr      = 32'h8000_3000;
            lsu_wen       = 1'b0;
            ifu_req_valid = (ig < ifu_n);
            ifu_addr      = 32'h8000_0100;
            #1;
            if (lsu_req_ready && ifu_req_ready) both = 1'b1;
            if (lsu_req_ready && ng < 4) begin gseq[ng] = 1'b1; ng++; lg++; end
            if (ifu_req_ready && ng < 4) begin gseq[ng] = 1'b0; ng++; ig++; end
            if (lsu_resp_valid && nr < 4) begin rseq[nr] = 1'b1; nr++; end
            if (ifu_resp_valid && nr < 4) begin rseq[nr] = 1'b0; nr++; end
        end
        lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        total++;
        if (nr != 4 || ng != 4) begin
            bad++;
            $display("FAIL simul_count: grants=%0d resps=%0d want 4/4", ng, nr);
        end
        total++;
        if (both) begin
            bad++;
            $display("FAIL simul_dual_ready: got both readies high, want one winner");
        end
        total++;
        if (gseq !== exp_seq) begin
            bad++;
            $display("FAIL simul_grant_order: got %b want %b (bit=1 LSU)", gseq, exp_seq);
        end
        total++;
        if (rseq !== exp_seq) begin
            bad++;
            $display("FAIL simul_resp_order: got %b want %b (bit=1 LSU)", rseq, exp_seq);
        end
    endtask

    task automatic test_ifu_only;
        tick;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        total++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ifu_accept: ifu_ready=%b lsu_ready=%b want 1/0", ifu_req_ready, lsu_req_ready);
        end
        tick;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== 4'h0) begin
            bad++;
            $display("FAIL ifu_mem_req: valid=%b addr=%h wen=%b wmask=%h want 1/80000000/0/0",
                     mem_req_valid, mem_addr, mem_wen, mem_wmask);
        end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ifu_wait: mem_req_valid=%b ifu_resp=%b want 0/0", mem_req_valid, ifu_resp_valid);
        end
        tick;
        mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        total++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL ifu_resp: valid=%b rdata=%h lsu_resp=%b want 1/00000413/0",
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid);
        end
        tick;
        total++;
        if (ifu_resp_valid !== 1'b0 || ifu_rdata !== 32'h0000_0413) begin
            bad++;
            $display("FAIL ifu_resp_pulse: valid=%b rdata=%h want 0/00000413", ifu_resp_valid, ifu_rdata);
        end
    endtask

    task automatic test_lsu_store;
        int lsu_pulses, ifu_pulses;
        lsu_pulses = 0; ifu_pulses = 0;
        tick;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        total++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL store_accept: lsu_ready=%b ifu_ready=%b want 1/0", lsu_req_ready, ifu_req_ready);
        end
        tick;
        lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
            mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
            bad++;
            $display("FAIL store_payload: valid=%b addr=%h wen=%b wdata=%h wmask=%h want 1/80001000/1/deadbeef/f",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick;
            mem_resp_valid = 1'b0;
            #1;
            if (lsu_resp_valid === 1'b1) lsu_pulses++;
            if (ifu_resp_valid === 1'b1) ifu_pulses++;
        end
        total++;
        if (lsu_pulses != 1 || ifu_pulses != 0) begin
            bad++;
            $display("FAIL store_resp: lsu_pulses=%0d ifu_pulses=%0d want 1/0", lsu_pulses, ifu_pulses);
        end
    endtask

    task automatic test_stall;
        logic ok;
        ok = 1'b1;
        tick;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0; lsu_wmask = 4'h0;
        tick;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; lsu_addr = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick;
            mem_req_ready = 1'b0;
            #1;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_2000 || mem_wen !== 1'b0 ||
                ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                ok = 1'b0;
                $display("FAIL stall_hold: cyc=%0d valid=%b addr=%h wen=%b rdy=%b%b want 1/80002000/0/00",
                         i, mem_req_valid, mem_addr, mem_wen, ifu_req_ready, lsu_req_ready);
            end
        end
        total++;
        if (!ok) bad++;
        tick;
        mem_req_ready = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        total++;
        if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h55AA_55AA || ifu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_resp: lsu_resp=%b rdata=%h ifu_resp=%b want 1/55aa55aa/0",
                     lsu_resp_valid, lsu_rdata, ifu_resp_valid);
        end
    endtask

    task automatic test_spurious;
        tick;
        mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        total++;
        if (arb_err !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL spurious_err: arb_err=%b ifu_resp=%b lsu_resp=%b want 1/0/0",
                     arb_err, ifu_resp_valid, lsu_resp_valid);
        end
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        tick;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        total++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0073 || arb_err !== 1'b1) begin
            bad++;
            $display("FAIL spurious_recover: ifu_resp=%b rdata=%h arb_err=%b want 1/00100073/1",
                     ifu_resp_valid, ifu_rdata, arb_err);
        end
    endtask

    task automatic test_reset_in_wait;
        tick;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        tick;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, arb_err} !== 6'd0 ||
            mem_addr !== 32'h0 || ifu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_in_wait: ctrl=%b addr=%h ifu_rdata=%h want 000000/0/0",
                     {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, arb_err},
                     mem_addr, ifu_rdata);
        end
        tick;
        rst = 1'b0;
        tick;
        mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick;
        mem_resp_valid = 1'b0;
        #1;
        total++;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || arb_err !== 1'b1 || ifu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_late_resp: ifu_resp=%b lsu_resp=%b arb_err=%b ifu_rdata=%h want 0/0/1/0",
                     ifu_resp_valid, lsu_resp_valid, arb_err, ifu_rdata);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_simultaneous;
        test_ifu_only;
        test_lsu_store;
        test_stall;
        test_spurious;
        test_reset_in_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
